half_adder_checker: RTL and testbench
=====================================

HALF_ADDER_CHECKER -- requirements
Module: half_adder_checker

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CNT_W, default 8: width of the check and error counters; legal range 2..16.
REQ-003 clk  input  1  Clock; all state updates on the rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 clear  input  1  Synchronous clear of all results and state.
REQ-006 in_valid  input  1  Qualifies one observation (a, b, sum, carry) in this cycle.
REQ-007 a, b  input  1 each  Operands applied to the half adder under test.
REQ-008 sum, carry  input  1 each  Responses observed from the half adder under test.
REQ-009 covered  output  4  Bit {a,b} is set once that input combination has been observed.
REQ-010 all_covered  output  1  Equals &covered.
REQ-011 check_count  output  CNT_W  Number of accepted observations, saturating.
REQ-012 err_count  output  CNT_W  Number of mismatching observations, saturating.
REQ-013 fail_vec  output  4  {a,b,sum,carry} of the first mismatch; holds until rst or clear.
REQ-014 state  output  2  Checker state: IDLE=0, CHECKING=1, PASS=2, FAIL=3.

Function
REQ-015 Expected values SHALL be exp_sum = a^b and exp_carry = a&b.
REQ-016 A mismatch SHALL be (sum != exp_sum) or (carry != exp_carry) on a cycle with in_valid=1.
REQ-017 Inputs are ignored when in_valid=0; no output changes in that case.
REQ-018 All outputs SHALL be registered; an observation is reflected on every output exactly 1 cycle after the sampling edge.
REQ-019 check_count SHALL increment by 1 per accepted observation and hold at 2^CNT_W-1 without wrapping.
REQ-020 err_count SHALL increment by 1 per mismatch and saturate identically.
REQ-021 covered[{a,b}] SHALL be set on every accepted observation, whether matching or not; bits are sticky.
REQ-022 fail_vec SHALL capture only while err_count==0 (first mismatch); later mismatches do not overwrite it.
REQ-023 State transitions, evaluated on each accepted observation:
  - IDLE -> CHECKING on a matching observation; IDLE -> FAIL on a mismatch.
  - CHECKING -> PASS when the updated covered==4'b1111 and there is no mismatch this cycle.
  - CHECKING or PASS -> FAIL on any mismatch.
  - FAIL is sticky until rst or clear.
  - PASS with a further matching observation remains in PASS.
REQ-024 The state SHALL go directly IDLE -> PASS never, because at least 4 observations are required.
REQ-025 clear=1 SHALL return all outputs to reset values at the next edge; a simultaneous in_valid observation is discarded.
REQ-026 Repeated identical observations SHALL count in check_count but not alter covered.

Reset
REQ-027 When rst is asserted, covered=0, all_covered=0, check_count=0, err_count=0, fail_vec=0, and state=IDLE, immediately and independent of clk.
REQ-028 Deassertion of rst SHALL take effect synchronously with clk; the first observation is accepted on the first rising edge with rst low.
REQ-029 Reset asserted mid-sequence SHALL discard all accumulated coverage and counts.

Verification
REQ-030 Exhaustive correct sweep: four observations {a,b}=00,01,10,11 with correct sum/carry -> covered=1111, check_count=4, err_count=0, state PASS one cycle after the 4th.
REQ-031 Injected fault: observation {a,b}=11 with sum=0,carry=0, then one correct observation -> state=FAIL, err_count=1, fail_vec=4'b1100, and FAIL persists.
REQ-032 Saturation with CNT_W=2: six mismatching observations -> err_count=3, check_count=3, fail_vec holds the first mismatch.
REQ-033 Clear priority: clear=1 together with in_valid=1 from PASS -> next cycle all outputs zero and state IDLE; the sample is not counted.
REQ-034 Async reset mid-sweep: rst pulsed between clock edges after 2 observations -> outputs zero before the next edge; a subsequent full sweep reaches PASS with check_count=4.
REQ-035 Idle gaps: in_valid=0 cycles interleaved with a correct sweep -> outputs unchanged during gaps, and the final result is identical to REQ-030.

Source files
------------

// File: rtl/half_adder_checker_if.sv
// Observation bundle presented to the half adder checker.
// master drives one (a, b, sum, carry) sample qualified by in_valid.
interface half_adder_checker_if;
  logic in_valid;
  logic a;
  logic b;
  logic sum;
  logic carry;

  modport master (
    output in_valid, a, b, sum, carry
  );

  modport slave (
    input in_valid, a, b, sum, carry
  );
endinterface

// File: rtl/half_adder_checker.sv
// Online checker for a half adder: coverage, saturating counters,
// first-failure capture and a pass/fail verdict, all registered.
module half_adder_checker #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  half_adder_checker_if.slave  obs,
  output logic [3:0]           covered,
  output logic                 all_covered,
  output logic [CNT_W-1:0]     check_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [3:0]           fail_vec,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECKING = 2'd1,
    PASS     = 2'd2,
    FAIL     = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  st_t        st;
  st_t        st_n;
  logic       mis;
  logic [1:0] idx;
  logic [3:0] cov_n;

  assign idx   = {obs.a, obs.b};
  assign mis   = (obs.sum != (obs.a ^ obs.b))
               | (obs.carry != (obs.a & obs.b));
  assign cov_n = covered | (4'b0001 << idx);
  assign state = st;

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:     st_n = mis ? FAIL : CHECKING;
      CHECKING: begin
        if (mis)                 st_n = FAIL;
        else if (cov_n == 4'hf)  st_n = PASS;
        else                     st_n = CHECKING;
      end
      PASS:     st_n = mis ? FAIL : PASS;
      FAIL:     st_n = FAIL;
      default:  st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      covered     <= '0;
      all_covered <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
      fail_vec    <= '0;
    end else if (clear) begin
      st          <= IDLE;
      covered     <= '0;
      all_covered <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
      fail_vec    <= '0;
    end else if (obs.in_valid) begin
      st          <= st_n;
      covered     <= cov_n;
      all_covered <= &cov_n;
      if (check_count != CNT_MAX)
        check_count <= check_count + 1'b1;
      if (mis) begin
        if (err_count != CNT_MAX)
          err_count <= err_count + 1'b1;
        // only the first mismatch is kept
        if (err_count == '0)
          fail_vec <= {obs.a, obs.b, obs.sum, obs.carry};
      end
    end
  end

endmodule

// File: tb/tb_half_adder_checker.sv
// Scoreboard bench for half_adder_checker (CNT_W=8 and CNT_W=2).
// Driver pushes model snapshots; a negedge monitor pops and compares.
module tb_half_adder_checker;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  half_adder_checker_if hif ();

  logic [3:0] cov8, cov2, fv8, fv2;
  logic       all8, all2;
  logic [7:0] chk8, err8;
  logic [1:0] chk2, err2;
  logic [1:0] st8, st2;

  half_adder_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .obs(hif.slave),
    .covered(cov8), .all_covered(all8),
    .check_count(chk8), .err_count(err8),
    .fail_vec(fv8), .state(st8)
  );

  half_adder_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .obs(hif.slave),
    .covered(cov2), .all_covered(all2),
    .check_count(chk2), .err_count(err2),
    .fail_vec(fv2), .state(st2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cov;
    logic       all;
    int         chk8;
    int         err8;
    int         chk2;
    int         err2;
    logic [3:0] fv;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: a history summary, not a state machine
  bit   seen[4];
  int   n_chk;
  int   n_err;
  logic [3:0] first_fail;

  function automatic void chk(string nm, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) seen[i] = 0;
    n_chk = 0;
    n_err = 0;
    first_fail = '0;
  endfunction

  function automatic int sat(int n, int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.cov = {seen[3], seen[2], seen[1], seen[0]};
    e.all = &e.cov;
    e.chk8 = sat(n_chk, 8);
    e.err8 = sat(n_err, 8);
    e.chk2 = sat(n_chk, 2);
    e.err2 = sat(n_err, 2);
    e.fv = first_fail;
    if (n_err > 0)      e.st = 2'd3;
    else if (e.all)     e.st = 2'd2;
    else if (n_chk > 0) e.st = 2'd1;
    else                e.st = 2'd0;
    return e;
  endfunction

  task automatic step(bit v, bit a, bit b, bit s, bit c, bit clr);
    @(negedge clk);
    hif.in_valid = v;
    hif.a = a;
    hif.b = b;
    hif.sum = s;
    hif.carry = c;
    clear = clr;
    @(posedge clk);
    #1;
    if (clr) model_reset();
    else if (v) begin
      n_chk++;
      seen[{a, b}] = 1;
      if (s != (a ^ b) || c != (a & b)) begin
        if (n_err == 0) first_fail = {a, b, s, c};
        n_err++;
      end
    end
    q.push_back(snapshot());
    hif.in_valid = 0;
    clear = 0;
  endtask

  task automatic good(bit a, bit b);
    step(1, a, b, a ^ b, a & b, 0);
  endtask

  task automatic gap();
    step(0, $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), 0);
  endtask

  task automatic do_clear();
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".cov"}, cov8, 0);
    chk({tag, ".all"}, all8, 0);
    chk({tag, ".chk"}, chk8, 0);
    chk({tag, ".err"}, err8, 0);
    chk({tag, ".fv"}, fv8, 0);
    chk({tag, ".st"}, st8, 0);
    chk({tag, ".chk2"}, chk2, 0);
    chk({tag, ".st2"}, st2, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("covered", cov8, e.cov);
      chk("all_covered", all8, e.all);
      chk("check_count", chk8, e.chk8);
      chk("err_count", err8, e.err8);
      chk("fail_vec", fv8, e.fv);
      chk("state", st8, e.st);
      chk("covered_w2", cov2, e.cov);
      chk("check_count_w2", chk2, e.chk2);
      chk("err_count_w2", err2, e.err2);
      chk("fail_vec_w2", fv2, e.fv);
      chk("state_w2", st2, e.st);
    end
  end

  initial begin
    int f;
    bit a, b, v;
    hif.in_valid = 0;
    hif.a = 0;
    hif.b = 0;
    hif.sum = 0;
    hif.carry = 0;
    clear = 0;
    rst = 1;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 0;

    // exhaustive correct sweep
    good(0, 0); good(0, 1); good(1, 0); good(1, 1);
    good(1, 1);

    // clear with a simultaneous sample from PASS
    step(1, 0, 1, 1, 0, 1);

    // injected fault then a correct sample
    step(1, 1, 1, 0, 0, 0);
    good(0, 1);
    good(0, 0);
    do_clear();

    // saturation: six mismatches
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 0);
    do_clear();

    // async reset between edges after two samples
    good(0, 0); good(1, 1);
    @(negedge clk);
    #2 rst = 1;
    #1 check_zero("async_rst");
    model_reset();
    #1 rst = 0;
    good(0, 0); good(0, 1); good(1, 0); good(1, 1);
    do_clear();

    // sweep with idle gaps
    good(1, 1); gap(); gap();
    good(0, 1); gap();
    good(0, 1); gap();
    good(0, 0); gap(); gap();
    good(1, 0); gap(); gap();
    do_clear();

    // randomized traffic with occasional faults and clears
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a = $urandom_range(0, 1);
      b = $urandom_range(0, 1);
      f = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
      step(v, a, b, (a ^ b) ^ f[1], (a & b) ^ f[0],
           $urandom_range(0, 59) == 0);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
